line_ram_ctrl: RTL

Controller that sequences and shares one single-port, 128-bit × 128-line synchronous line RAM (registered address, registered output, two-cycle read latency) between a read requester (lookup side) and a write requester (line-fill side). After reset, and on every flush request, it first clears the whole RAM to zero. It sits between the cache/line-buffer logic and the line RAM and drives all RAM ports.

---
 rtl/line_ram_ctrl_if.sv | 46 ++++
 rtl/line_ram_ctrl.sv | 132 +++++++++++++
 2 files changed

// File: rtl/line_ram_ctrl_if.sv
// rtl/line_ram_ctrl_if.sv - request, grant and RAM-port bundle for line_ram_ctrl
//
// Purpose: groups the lookup-side read port, the line-fill write port, the
// flush/busy pair and the line RAM ports into one bundle.
// Ports (signals):
//   i_flush, o_busy                       flush pulse / controller busy
//   i_rd_req, i_rd_addr, o_rd_gnt          read request and grant
//   o_rd_valid, o_rd_data                  read return
//   i_wr_req, i_wr_addr, i_wr_data, o_wr_gnt  write request and grant
//   o_ram_address, o_ram_write_data,
//   o_ram_write_enable, i_ram_read_data    line RAM ports
// Modports: slave = controller side, master = requester/RAM side.
interface line_ram_ctrl_if #(
   parameter int DATA_WIDTH    = 128,
   parameter int ADDRESS_WIDTH = 7
);
   logic                     i_flush;
   logic                     o_busy;
   logic                     i_rd_req;
   logic [ADDRESS_WIDTH-1:0] i_rd_addr;
   logic                     o_rd_gnt;
   logic                     o_rd_valid;
   logic [DATA_WIDTH-1:0]    o_rd_data;
   logic                     i_wr_req;
   logic [ADDRESS_WIDTH-1:0] i_wr_addr;
   logic [DATA_WIDTH-1:0]    i_wr_data;
   logic                     o_wr_gnt;
   logic [ADDRESS_WIDTH-1:0] o_ram_address;
   logic [DATA_WIDTH-1:0]    o_ram_write_data;
   logic                     o_ram_write_enable;
   logic [DATA_WIDTH-1:0]    i_ram_read_data;

   modport slave (
      input  i_flush, i_rd_req, i_rd_addr, i_wr_req, i_wr_addr, i_wr_data,
             i_ram_read_data,
      output o_busy, o_rd_gnt, o_rd_valid, o_rd_data, o_wr_gnt,
             o_ram_address, o_ram_write_data, o_ram_write_enable
   );

   modport master (
      output i_flush, i_rd_req, i_rd_addr, i_wr_req, i_wr_addr, i_wr_data,
             i_ram_read_data,
      input  o_busy, o_rd_gnt, o_rd_valid, o_rd_data, o_wr_gnt,
             o_ram_address, o_ram_write_data, o_ram_write_enable
   );
endinterface

// File: rtl/line_ram_ctrl.sv
// rtl/line_ram_ctrl.sv - shares one single-port line RAM between a reader and a writer
//
// Purpose: zero-clears the whole line RAM after reset and on every flush,
// then arbitrates one grant per cycle between the read and write requesters
// (alternating on ties) and drives every RAM port.
// Ports:
//   i_clk    clock, all state changes on the rising edge
//   i_rst_n  asynchronous active-low reset
//   bus      line_ram_ctrl_if slave: flush/busy, read and write ports, RAM ports
module line_ram_ctrl #(
   parameter int DATA_WIDTH    = 128,
   parameter int ADDRESS_WIDTH = 7
) (
   input  logic           i_clk,
   input  logic           i_rst_n,
   line_ram_ctrl_if.slave bus
);

   typedef enum logic [1:0] {START, CLEAR, RUN} state_t;

   localparam logic [ADDRESS_WIDTH-1:0] LAST_LINE = '1;
   localparam logic GNT_RD = 1'b0;
   localparam logic GNT_WR = 1'b1;

   state_t                   state;
   logic                     busy_q;
   logic [ADDRESS_WIDTH-1:0] clr_cnt;
   logic                     last_gnt;
   logic [1:0]               rd_pipe;
   logic [ADDRESS_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0]    data_q;

   logic                     arb_ok;
   logic                     rd_gnt;
   logic                     wr_gnt;
   logic [ADDRESS_WIDTH-1:0] ram_address;
   logic [DATA_WIDTH-1:0]    ram_write_data;
   logic                     ram_write_enable;

   // A flush in RUN takes priority over any request that cycle.
   always_comb begin
      arb_ok = (state == RUN) && !bus.i_flush;
      rd_gnt = arb_ok && bus.i_rd_req && (!bus.i_wr_req || last_gnt == GNT_WR);
      wr_gnt = arb_ok && bus.i_wr_req && (!bus.i_rd_req || last_gnt == GNT_RD);
   end

   // RAM port mux; with no grant the address/data registers replay the last
   // values driven so the RAM inputs stay quiet.
   always_comb begin
      ram_address      = addr_q;
      ram_write_data   = data_q;
      ram_write_enable = 1'b0;
      if (state == CLEAR) begin
         ram_address      = clr_cnt;
         ram_write_data   = '0;
         ram_write_enable = 1'b1;
      end else if (rd_gnt) begin
         ram_address = bus.i_rd_addr;
      end else if (wr_gnt) begin
         ram_address      = bus.i_wr_addr;
         ram_write_data   = bus.i_wr_data;
         ram_write_enable = 1'b1;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state   <= START;
         busy_q  <= 1'b1;
         clr_cnt <= '0;
      end else begin
         case (state)
            START: begin
               state   <= CLEAR;
               busy_q  <= 1'b1;
               clr_cnt <= '0;
            end
            CLEAR: begin
               if (bus.i_flush) begin
                  clr_cnt <= '0;
               end else if (clr_cnt == LAST_LINE) begin
                  state   <= RUN;
                  busy_q  <= 1'b0;
                  clr_cnt <= '0;
               end else begin
                  clr_cnt <= clr_cnt + 1'b1;
               end
            end
            RUN: begin
               if (bus.i_flush) begin
                  state   <= CLEAR;
                  busy_q  <= 1'b1;
                  clr_cnt <= '0;
               end
            end
            default: begin
               state  <= START;
               busy_q <= 1'b1;
            end
         endcase
      end
   end

   // Read-valid pipe ignores state so reads granted before a flush complete.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         last_gnt <= GNT_WR;
         rd_pipe  <= '0;
         addr_q   <= '0;
         data_q   <= '0;
      end else begin
         rd_pipe <= {rd_pipe[0], rd_gnt};
         addr_q  <= ram_address;
         data_q  <= ram_write_data;
         if (rd_gnt) begin
            last_gnt <= GNT_RD;
         end else if (wr_gnt) begin
            last_gnt <= GNT_WR;
         end
      end
   end

   assign bus.o_busy             = busy_q;
   assign bus.o_rd_gnt           = rd_gnt;
   assign bus.o_wr_gnt           = wr_gnt;
   assign bus.o_rd_valid         = rd_pipe[1];
   assign bus.o_rd_data          = bus.i_ram_read_data;
   assign bus.o_ram_address      = ram_address;
   assign bus.o_ram_write_data   = ram_write_data;
   assign bus.o_ram_write_enable = ram_write_enable;

endmodule
